// File: rtl/csr_trap_ctrl_pkg.sv
// Shared CSR addresses, exception codes and the trap sequencer state type.
package csr_trap_ctrl_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;

    localparam logic [5:0] ECODE_INT = 6'h00;

    typedef enum logic [2:0] {
        IDLE,
        W_ERA,
        W_PRMD,
        W_CRMD,
        W_ESTAT,
        W_BADV,
        E_CRMD,
        REDIR
    } trap_state_t;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Arbitrates the single CSR write port between software csrwr/csrxchg and the
// multi-cycle exception, interrupt and ERTN write sequences; drives flush/redirect.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int INT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    output logic              commit_ready,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic              excp_valid,
    input  logic [5:0]        excp_ecode,
    input  logic [8:0]        excp_esubcode,
    input  logic              badv_valid,
    input  logic [DATA_W-1:0] badv_addr,
    input  logic              ertn,
    input  logic              sw_we,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_wdata,
    input  logic [DATA_W-1:0] sw_wmask,
    input  logic [DATA_W-1:0] crmd,
    input  logic [DATA_W-1:0] prmd,
    input  logic [DATA_W-1:0] ecfg,
    input  logic [DATA_W-1:0] estat,
    input  logic [DATA_W-1:0] era,
    input  logic [DATA_W-1:0] eentry,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic [DATA_W-1:0] csr_wmask,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              busy
);

    trap_state_t state, state_next;

    logic              int_pending;
    logic              take_trap;
    logic              take_ertn;
    logic              take_sw;

    logic [DATA_W-1:0] lat_pc;
    logic [2:0]        lat_crmd;
    logic [5:0]        lat_ecode;
    logic [8:0]        lat_esubcode;
    logic              lat_badv_valid;
    logic [DATA_W-1:0] lat_badv_addr;
    logic              lat_ertn;

    logic              unused_bits;

    assign int_pending = crmd[2] & (|(estat[INT_W-1:0] & ecfg[INT_W-1:0]));
    assign take_trap   = commit_valid & (int_pending | excp_valid);
    assign take_ertn   = commit_valid & ~take_trap & ertn;
    assign take_sw     = commit_valid & sw_we & ~int_pending & ~excp_valid & ~ertn;

    assign unused_bits = ^{crmd[DATA_W-1:3], prmd[DATA_W-1:3],
                           ecfg[DATA_W-1:INT_W], estat[DATA_W-1:INT_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_trap) begin
                    state_next = W_ERA;
                end else if (take_ertn) begin
                    state_next = E_CRMD;
                end
            end
            W_ERA:   state_next = W_PRMD;
            W_PRMD:  state_next = W_CRMD;
            W_CRMD:  state_next = W_ESTAT;
            W_ESTAT: state_next = lat_badv_valid ? W_BADV : REDIR;
            W_BADV:  state_next = REDIR;
            E_CRMD:  state_next = REDIR;
            REDIR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot of the trapping instruction; interrupts report ecode 0 and no bad address.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_pc         <= '0;
            lat_crmd       <= '0;
            lat_ecode      <= '0;
            lat_esubcode   <= '0;
            lat_badv_valid <= 1'b0;
            lat_badv_addr  <= '0;
            lat_ertn       <= 1'b0;
        end else if (state == IDLE && take_trap) begin
            lat_pc         <= commit_pc;
            lat_crmd       <= crmd[2:0];
            lat_badv_addr  <= badv_addr;
            lat_ertn       <= 1'b0;
            if (int_pending) begin
                lat_ecode      <= ECODE_INT;
                lat_esubcode   <= '0;
                lat_badv_valid <= 1'b0;
            end else begin
                lat_ecode      <= excp_ecode;
                lat_esubcode   <= excp_esubcode;
                lat_badv_valid <= badv_valid;
            end
        end else if (state == IDLE && take_ertn) begin
            lat_ertn <= 1'b1;
        end
    end

    always_comb begin
        csr_we       = 1'b0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        csr_wmask    = '0;
        flush        = 1'b0;
        redirect_pc  = '0;
        busy         = (state != IDLE);
        commit_ready = (state == IDLE);
        case (state)
            IDLE: begin
                if (take_sw) begin
                    csr_we    = 1'b1;
                    csr_waddr = sw_addr;
                    csr_wdata = sw_wdata;
                    csr_wmask = sw_wmask;
                end
            end
            W_ERA: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_ERA);
                csr_wdata = lat_pc;
                csr_wmask = '1;
            end
            W_PRMD: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_PRMD);
                csr_wdata = DATA_W'(lat_crmd);
                csr_wmask = DATA_W'(3'h7);
            end
            W_CRMD: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_CRMD);
                csr_wmask = DATA_W'(3'h7);
            end
            W_ESTAT: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_ESTAT);
                csr_wdata = DATA_W'({1'b0, lat_esubcode, lat_ecode, 16'h0000});
                csr_wmask = DATA_W'(32'h7FFF_0000);
            end
            W_BADV: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_BADV);
                csr_wdata = lat_badv_addr;
                csr_wmask = '1;
            end
            E_CRMD: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_W'(CSR_CRMD);
                csr_wdata = DATA_W'(prmd[2:0]);
                csr_wmask = DATA_W'(3'h7);
            end
            REDIR: begin
                flush       = 1'b1;
                redirect_pc = lat_ertn ? era : eentry;
            end
            default: ;
        endcase
        // Reset silences everything immediately, including the software passthrough.
        if (rst) begin
            csr_we       = 1'b0;
            csr_waddr    = '0;
            csr_wdata    = '0;
            csr_wmask    = '0;
            flush        = 1'b0;
            redirect_pc  = '0;
            busy         = 1'b0;
            commit_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Randomized bench for csr_trap_ctrl; expected per-cycle port activity is
// derived from the trap/ERTN/software-write rules as a queue of cycle records.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic        excp_valid;
    logic [5:0]  excp_ecode;
    logic [8:0]  excp_esubcode;
    logic        badv_valid;
    logic [31:0] badv_addr;
    logic        ertn;
    logic        sw_we;
    logic [13:0] sw_addr;
    logic [31:0] sw_wdata;
    logic [31:0] sw_wmask;
    logic [31:0] crmd, prmd, ecfg, estat, era, eentry;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic        flush;
        logic [31:0] rpc;
        logic        busy;
        logic        ready;
    } cyc_t;

    cyc_t exp_q[$];

    always #5 clk = ~clk;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
        .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
        .badv_valid(badv_valid), .badv_addr(badv_addr), .ertn(ertn),
        .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_wmask(sw_wmask),
        .crmd(crmd), .prmd(prmd), .ecfg(ecfg), .estat(estat), .era(era), .eentry(eentry),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .flush(flush), .redirect_pc(redirect_pc), .busy(busy)
    );

    function automatic logic [113:0] pack_actual();
        return {csr_we, csr_waddr, csr_wdata, csr_wmask, flush, redirect_pc, busy, commit_ready};
    endfunction

    function automatic logic [113:0] pack_exp(input cyc_t c);
        return {c.we, c.addr, c.data, c.mask, c.flush, c.rpc, c.busy, c.ready};
    endfunction

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c = '{we: 1'b0, addr: 14'h0, data: 32'h0, mask: 32'h0, flush: 1'b0,
              rpc: 32'h0, busy: 1'b0, ready: 1'b1};
        return c;
    endfunction

    function automatic cyc_t busy_cyc(input logic we, input logic [13:0] addr,
                                      input logic [31:0] data, input logic [31:0] mask);
        cyc_t c;
        c = '{we: we, addr: addr, data: data, mask: mask, flush: 1'b0,
              rpc: 32'h0, busy: 1'b1, ready: 1'b0};
        return c;
    endfunction

    // Reference model: turns the inputs presented in the accept cycle into the list
    // of per-cycle outputs, ending with the first idle cycle after the sequence.
    task automatic build_expected();
        cyc_t       c;
        logic       int_p;
        logic [5:0] code;
        logic [8:0] sub;
        exp_q.delete();
        int_p = crmd[2] && ((estat & ecfg & 32'h0000_1FFF) != 32'h0);
        if (commit_valid && (int_p || excp_valid)) begin
            exp_q.push_back(idle_cyc());
            exp_q.push_back(busy_cyc(1'b1, 14'h6, commit_pc, 32'hFFFF_FFFF));
            exp_q.push_back(busy_cyc(1'b1, 14'h1, {29'h0, crmd[2:0]}, 32'h7));
            exp_q.push_back(busy_cyc(1'b1, 14'h0, 32'h0, 32'h7));
            code = int_p ? 6'h0 : excp_ecode;
            sub  = int_p ? 9'h0 : excp_esubcode;
            exp_q.push_back(busy_cyc(1'b1, 14'h5, {1'b0, sub, code, 16'h0}, 32'h7FFF_0000));
            if (!int_p && badv_valid)
                exp_q.push_back(busy_cyc(1'b1, 14'h7, badv_addr, 32'hFFFF_FFFF));
            c = busy_cyc(1'b0, 14'h0, 32'h0, 32'h0);
            c.flush = 1'b1;
            c.rpc   = eentry;
            exp_q.push_back(c);
            exp_q.push_back(idle_cyc());
        end else if (commit_valid && ertn) begin
            exp_q.push_back(idle_cyc());
            exp_q.push_back(busy_cyc(1'b1, 14'h0, {29'h0, prmd[2:0]}, 32'h7));
            c = busy_cyc(1'b0, 14'h0, 32'h0, 32'h0);
            c.flush = 1'b1;
            c.rpc   = era;
            exp_q.push_back(c);
            exp_q.push_back(idle_cyc());
        end else begin
            c = idle_cyc();
            if (commit_valid && sw_we) begin
                c.we   = 1'b1;
                c.addr = sw_addr;
                c.data = sw_wdata;
                c.mask = sw_wmask;
            end
            exp_q.push_back(c);
        end
    endtask

    task automatic quiet_inputs();
        commit_valid = 1'b0; commit_pc = 32'h0;
        excp_valid = 1'b0; excp_ecode = 6'h0; excp_esubcode = 9'h0;
        badv_valid = 1'b0; badv_addr = 32'h0; ertn = 1'b0;
        sw_we = 1'b0; sw_addr = 14'h0; sw_wdata = 32'h0; sw_wmask = 32'h0;
        crmd = 32'h0; prmd = 32'h0; ecfg = 32'h0; estat = 32'h0;
        era = 32'h0; eentry = 32'h0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        commit_valid = 1'b1; sw_we = 1'b1; sw_addr = 14'h30;
        sw_wdata = 32'hDEAD_BEEF; sw_wmask = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (pack_actual() !== 114'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", pack_actual(), 114'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        commit_valid = 1'b0; sw_we = 1'b0;
        @(negedge clk);
        tests_run++;
        if (pack_actual() !== pack_exp(idle_cyc())) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %h expected %h",
                     pack_actual(), pack_exp(idle_cyc()));
        end
    endtask

    task automatic test_sw_write();
        cyc_t c;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            quiet_inputs();
            if (n == 0) begin
                commit_valid = 1'b1; sw_we = 1'b1; sw_addr = 14'h30;
                sw_wdata = 32'h0000_1234; sw_wmask = 32'hFFFF_FFFF;
            end else begin
                commit_valid = ($urandom_range(0, 3) != 0);
                sw_we        = ($urandom_range(0, 3) != 0);
                sw_addr      = 14'($urandom);
                sw_wdata     = $urandom;
                sw_wmask     = $urandom;
                commit_pc    = $urandom;
            end
            c = idle_cyc();
            if (commit_valid && sw_we) begin
                c.we = 1'b1; c.addr = sw_addr; c.data = sw_wdata; c.mask = sw_wmask;
            end
            @(negedge clk);
            tests_run++;
            if (pack_actual() !== pack_exp(c)) begin
                tests_failed++;
                $display("[TB] FAIL sw_write #%0d: got %h expected %h", n, pack_actual(), pack_exp(c));
            end
        end
        @(posedge clk); #1;
        quiet_inputs();
    endtask

    task automatic test_trap_sequences();
        int k;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            quiet_inputs();
            commit_valid = 1'b1;
            case (n)
                0: begin
                    commit_pc = 32'h1C00_0100; excp_valid = 1'b1; excp_ecode = 6'h8;
                    badv_valid = 1'b1; badv_addr = 32'h1C00_0102;
                    crmd = 32'h7; eentry = 32'h1C00_8000;
                end
                1: begin
                    commit_pc = 32'h1C00_0400; excp_valid = 1'b1; excp_ecode = 6'hB;
                    crmd = 32'h3; eentry = 32'h1C00_8000;
                end
                2: begin
                    commit_pc = 32'h1C00_0500; excp_valid = 1'b1; excp_ecode = 6'hB;
                    badv_valid = 1'b1; badv_addr = 32'h1111_2222;
                    sw_we = 1'b1; sw_addr = 14'h30; sw_wdata = 32'h55; sw_wmask = 32'hFF;
                    crmd = 32'h4; estat = 32'h0000_0800; ecfg = 32'h0000_0800;
                    eentry = 32'h1C00_9000;
                end
                3: begin
                    ertn = 1'b1; prmd = 32'h3; era = 32'h1C00_0200; eentry = 32'h1C00_8000;
                end
                default: begin
                    commit_pc     = $urandom;
                    excp_valid    = ($urandom_range(0, 2) == 0);
                    excp_ecode    = 6'($urandom);
                    excp_esubcode = 9'($urandom);
                    badv_valid    = $urandom_range(0, 1) == 1;
                    badv_addr     = $urandom;
                    ertn          = ($urandom_range(0, 2) == 0);
                    sw_we         = $urandom_range(0, 1) == 1;
                    sw_addr       = 14'($urandom);
                    sw_wdata      = $urandom;
                    sw_wmask      = $urandom;
                    crmd          = $urandom;
                    prmd          = $urandom;
                    k             = $urandom_range(0, 12);
                    estat         = ($urandom & 32'hFFFF_E000) | (32'h1 << k);
                    ecfg          = ($urandom & 32'hFFFF_E000) |
                                    (($urandom_range(0, 2) == 0) ? (32'h1 << k)
                                                                 : (32'h1 << ((k + 1) % 13)));
                    era           = $urandom;
                    eentry        = $urandom;
                end
            endcase
            build_expected();
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                    if (exp_q[i].busy) begin
                        commit_valid  = 1'b1;
                        commit_pc     = $urandom;
                        excp_valid    = $urandom_range(0, 1) == 1;
                        ertn          = $urandom_range(0, 1) == 1;
                        sw_we         = 1'b1;
                        sw_addr       = 14'($urandom);
                        sw_wdata      = $urandom;
                        sw_wmask      = $urandom;
                    end else begin
                        commit_valid = 1'b0;
                    end
                end
                @(negedge clk);
                tests_run++;
                if (pack_actual() !== pack_exp(exp_q[i])) begin
                    tests_failed++;
                    $display("[TB] FAIL trap_seq #%0d cycle %0d: got %h expected %h",
                             n, i, pack_actual(), pack_exp(exp_q[i]));
                end
            end
        end
        @(posedge clk); #1;
        quiet_inputs();
    endtask

    task automatic test_reset_mid_trap();
        cyc_t c;
        @(posedge clk); #1;
        quiet_inputs();
        commit_valid = 1'b1; commit_pc = 32'h1C00_0100; excp_valid = 1'b1;
        excp_ecode = 6'h8; badv_valid = 1'b1; badv_addr = 32'h1C00_0102;
        crmd = 32'h7; eentry = 32'h1C00_8000;
        repeat (3) begin
            @(posedge clk); #1;
            commit_valid = 1'b0;
        end
        @(negedge clk);
        c = busy_cyc(1'b1, 14'h0, 32'h0, 32'h7);
        tests_run++;
        if (pack_actual() !== pack_exp(c)) begin
            tests_failed++;
            $display("[TB] FAIL mid_trap_w_crmd: got %h expected %h", pack_actual(), pack_exp(c));
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (pack_actual() !== 114'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_trap_rst_high: got %h expected %h", pack_actual(), 114'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (pack_actual() !== pack_exp(idle_cyc())) begin
                tests_failed++;
                $display("[TB] FAIL mid_trap_after_rst cycle %0d: got %h expected %h",
                         i, pack_actual(), pack_exp(idle_cyc()));
            end
        end
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        test_reset();
        test_sw_write();
        test_trap_sequences();
        test_reset_mid_trap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Sequencer and arbiter for the single CSR write port of the CSR register file. It merges commit-stage software CSR writes (csrwr/csrxchg) with the multi-write sequences for exception, interrupt and ERTN. It drives the pipeline flush and redirect for traps. It sits between the commit stage and the CSR file. It consumes the current CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY values from the CSR read side.

Parameters:
ADDR_W, 14, CSR address width
DATA_W, 32, CSR data / PC width (GRLEN)
INT_W, 13, number of interrupt lines checked (ESTAT.IS / ECFG.LIE bits [12:0])

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
commit_valid  in  1  commit-stage instruction valid
commit_ready  out  1  block can accept a commit this cycle
commit_pc  in  DATA_W  PC of committing instruction
excp_valid  in  1  committing instruction raised an exception
excp_ecode  in  6  exception code
excp_esubcode  in  9  exception subcode
badv_valid  in  1  exception carries a bad virtual address
badv_addr  in  DATA_W  bad virtual address
ertn  in  1  committing instruction is ERTN
sw_we  in  1  software CSR write request
sw_addr  in  ADDR_W  software write address
sw_wdata  in  DATA_W  software write data
sw_wmask  in  DATA_W  software write bit mask
crmd, prmd, ecfg, estat, era, eentry  in  DATA_W each  current CSR values
csr_we  out  1  CSR file write enable
csr_waddr  out  ADDR_W  CSR file write address
csr_wdata  out  DATA_W  CSR file write data
csr_wmask  out  DATA_W  CSR file write mask
flush  out  1  one-cycle pipeline flush
redirect_pc  out  DATA_W  fetch target, valid with flush
busy  out  1  trap sequence in progress

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. Latches are cleared. csr_we=0, csr_waddr=0, csr_wdata=0, csr_wmask=0, flush=0, redirect_pc=0, busy=0, commit_ready=0 while rst is high. A reset mid-sequence abandons it; no further writes are issued.
- int_pending = crmd[2] & |(estat[INT_W-1:0] & ecfg[INT_W-1:0]).
- IDLE event priority for commit_valid=1: interrupt > exception > ERTN > software write.
- Interrupt or exception accepted at cycle T:
  - Latch pc, crmd[2:0], ecode/esubcode (interrupt uses 0/0), badv_valid and badv_addr (interrupt uses badv_valid=0).
  - busy=1 from T+1.
  - Sequence: W_ERA (T+1) -> W_PRMD (T+2) -> W_CRMD (T+3) -> W_ESTAT (T+4) -> W_BADV (T+5, only if latched badv_valid) -> REDIR -> IDLE.
- ERTN accepted at cycle T: E_CRMD (T+1) -> REDIR (T+2) -> IDLE.
- Per-state writes (csr_we=1 for exactly one cycle each):
  - W_ERA: addr CSR_ERA, data latched pc, mask all ones.
  - W_PRMD: addr CSR_PRMD, data {29'b0, latched crmd[2:0]}, mask 0x7.
  - W_CRMD: addr CSR_CRMD, data 0, mask 0x7 (PLV=0, IE=0).
  - W_ESTAT: addr CSR_ESTAT, data {1'b0, esubcode, ecode, 16'b0}, mask 0x7FFF_0000.
  - W_BADV: addr CSR_BADV, data latched badv_addr, mask all ones.
  - E_CRMD: addr CSR_CRMD, data {29'b0, prmd[2:0]} sampled in that cycle, mask 0x7.
- REDIR: flush=1 and csr_we=0 for one cycle. redirect_pc = eentry for traps, era for ERTN, both sampled in REDIR so the preceding writes are visible. busy drops in the next cycle.
- Software write: in IDLE with commit_valid & sw_we and no higher-priority event, the request passes combinationally to csr_we/addr/wdata/wmask in the same cycle (zero latency).
  - A software write coinciding with an exception or interrupt is dropped.
- commit_ready = (state==IDLE) & ~rst. Commits presented while not ready are ignored; upstream holds them.
- While busy, all commit inputs are ignored. Nested traps are impossible by construction.
- Outputs other than the software passthrough are decoded from registered state.

Decomposition:
- The shared CSR include/package holds the CSR address constants (CSR_CRMD=0x0, PRMD=0x1, ESTAT=0x5, ERA=0x6, BADV=0x7, EENTRY=0xC), the ECODE_INT=0 constant, and the FSM state enum typedef.
- A single module; no sub-module is needed.

Test Plan:
- Software write: commit_valid=1, sw_we=1, addr 0x30, wdata 0x1234, mask 0xFFFF_FFFF -> same-cycle csr_we=1 with those values. No flush, busy=0.
- ADEF exception: pc=0x1C00_0100, ecode=0x8, badv_valid=1, badv=0x1C00_0102, crmd=0x7, eentry=0x1C00_8000 -> five writes: ERA=0x1C00_0100, PRMD=0x7, CRMD=0, ESTAT[21:16]=0x8, BADV=0x1C00_0102. Then flush with redirect_pc=0x1C00_8000, and busy deasserts 7 cycles after accept.
- SYSCALL (ecode 0xB, badv_valid=0) -> W_BADV skipped; flush at T+5.
- Interrupt priority: estat[11]=1, ecfg[11]=1, crmd[2]=1, with excp_valid=1 and sw_we=1 in the same cycle -> interrupt sequence with ESTAT ecode=0 and ERA=commit_pc. The software write and the exception are dropped.
- ERTN: prmd=0x3, era=0x1C00_0200 -> T+1 CRMD write data 0x3 mask 0x7; T+2 flush with redirect_pc=0x1C00_0200.
- Reset mid-trap: assert rst during W_CRMD -> next cycle csr_we=0, busy=0, flush never asserted. After reset release, commit_ready=1.
